// File: rtl/max_pool_row_pair_gen_pkg.sv
// Shared definitions for the max-pool row-pair feeder.
// Holds the packed pixel word geometry (4 lanes x 12 bit, lane bit 11 is
// sign/guard, bits 10:0 magnitude), the per-lane magnitude field offsets,
// the row buffer sizing defaults and the feeder FSM state encoding.
package max_pool_row_pair_gen_pkg;

  localparam int unsigned DATA_W      = 48;
  localparam int unsigned LANE_W      = 12;
  localparam int unsigned LANES       = 4;
  localparam int unsigned LANE_MAG_W  = 11;
  localparam int unsigned MAX_ROW_LEN = 256;
  localparam int unsigned ADDR_W      = 8;

  // Magnitude field bounds of each lane (sign/guard bit sits just above MSB)
  localparam int unsigned LANE3_MAG_MSB = 46;
  localparam int unsigned LANE3_MAG_LSB = 36;
  localparam int unsigned LANE2_MAG_MSB = 34;
  localparam int unsigned LANE2_MAG_LSB = 24;
  localparam int unsigned LANE1_MAG_MSB = 22;
  localparam int unsigned LANE1_MAG_LSB = 12;
  localparam int unsigned LANE0_MAG_MSB = 10;
  localparam int unsigned LANE0_MAG_LSB = 0;

  // IDLE: wait for frame_start; FILL: even row into buffer;
  // PAIR: odd row against buffer; PASS: pooling disabled
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_PAIR = 2'd2,
    ST_PASS = 2'd3
  } state_t;

endpackage

// File: rtl/max_pool_row_pair_gen_if.sv
// Stream interface between the feeder and its neighbours.
// Input side : frame_start_i, row_len_i, pool_en_i, data_i, data_valid_i.
// Output side: data_1_o (upper/pass word), data_2_o (lower word or 0),
//              max_en_o, valid_o, row_done_o.
// master modport drives the inputs and observes the outputs; slave modport
// is the feeder itself.
interface max_pool_row_pair_gen_if #(
  parameter int unsigned DATA_W = max_pool_row_pair_gen_pkg::DATA_W,
  parameter int unsigned ADDR_W = max_pool_row_pair_gen_pkg::ADDR_W
);

  logic              frame_start_i;
  logic [ADDR_W-1:0] row_len_i;
  logic              pool_en_i;
  logic [DATA_W-1:0] data_i;
  logic              data_valid_i;

  logic [DATA_W-1:0] data_1_o;
  logic [DATA_W-1:0] data_2_o;
  logic              max_en_o;
  logic              valid_o;
  logic              row_done_o;

  modport master (
    output frame_start_i, row_len_i, pool_en_i, data_i, data_valid_i,
    input  data_1_o, data_2_o, max_en_o, valid_o, row_done_o
  );

  modport slave (
    input  frame_start_i, row_len_i, pool_en_i, data_i, data_valid_i,
    output data_1_o, data_2_o, max_en_o, valid_o, row_done_o
  );

endinterface

// File: rtl/max_pool_row_buf.sv
// Row buffer for the max-pool feeder: simple dual-port RAM, one write port
// and one read port, both synchronous, read data valid one cycle after the
// address. No reset so it maps onto block RAM.
// Ports: clk_i, wr_en_i/wr_addr_i/wr_data_i (write), rd_addr_i/rd_data_o (read).
module max_pool_row_buf #(
  parameter int unsigned DATA_W = 48,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/max_pool_row_pair_gen.sv
// Feeder for the 2x2 max-pool stage. Buffers each even row of packed pixel
// words and replays it next to the following odd row so the max-pool stage
// receives vertically adjacent words as data_1/data_2. With pooling off the
// words stream through on data_1 with max_en low.
// Ports: clk_i, rst_n_i (async, active-low), bus (slave modport carrying
// frame_start/row_len/pool_en/data/data_valid in, data_1/data_2/max_en/
// valid/row_done out). Fixed latency of 2 cycles from accepted word to
// valid_o.
module max_pool_row_pair_gen #(
  parameter int unsigned DATA_W      = max_pool_row_pair_gen_pkg::DATA_W,
  parameter int unsigned MAX_ROW_LEN = max_pool_row_pair_gen_pkg::MAX_ROW_LEN,
  parameter int unsigned ADDR_W      = max_pool_row_pair_gen_pkg::ADDR_W
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  max_pool_row_pair_gen_if.slave  bus
);

  import max_pool_row_pair_gen_pkg::*;

  // Frame configuration; row length is held as last column index so that
  // row_len 0 (meaning MAX_ROW_LEN) falls out of the 1-subtraction wrap.
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic [ADDR_W-1:0] last_col_q, last_col_d;
  logic              pool_en_q, pool_en_d;

  // Configuration seen by the current word, frame_start taking effect on
  // the same cycle so a coincident word is column 0 of the new frame.
  state_t            eff_state;
  logic [ADDR_W-1:0] eff_col;
  logic [ADDR_W-1:0] eff_last;
  logic              accept;
  logic              last_word;

  logic              wr_en;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] rd_data;

  // Stage 1: registered input word aligned with the buffer read
  logic              s1_valid_q, s1_valid_d;
  logic              s1_pair_q, s1_pair_d;
  logic              s1_last_q, s1_last_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;

  // Stage 2: output registers
  logic [DATA_W-1:0] data_1_q, data_1_d;
  logic [DATA_W-1:0] data_2_q, data_2_d;
  logic              max_en_q, max_en_d;
  logic              valid_q, valid_d;
  logic              row_done_q, row_done_d;

  always_comb begin
    eff_state  = state_q;
    eff_col    = col_q;
    eff_last   = last_col_q;
    pool_en_d  = pool_en_q;
    last_col_d = last_col_q;

    if (bus.frame_start_i) begin
      pool_en_d  = bus.pool_en_i;
      last_col_d = bus.row_len_i - ADDR_W'(1);
      eff_last   = bus.row_len_i - ADDR_W'(1);
      eff_col    = '0;
      eff_state  = bus.pool_en_i ? ST_FILL : ST_PASS;
    end

    accept    = bus.data_valid_i && (eff_state != ST_IDLE);
    last_word = (eff_col == eff_last);

    state_d    = eff_state;
    col_d      = eff_col;
    wr_en      = 1'b0;
    buf_addr   = eff_col;
    s1_valid_d = 1'b0;
    s1_pair_d  = 1'b0;
    s1_last_d  = 1'b0;
    s1_data_d  = s1_data_q;

    if (accept) begin
      col_d = last_word ? '0 : eff_col + ADDR_W'(1);
      unique case (eff_state)
        ST_FILL: begin
          wr_en = 1'b1;
          if (last_word) state_d = ST_PAIR;
        end
        ST_PAIR: begin
          s1_valid_d = 1'b1;
          s1_pair_d  = 1'b1;
          s1_last_d  = last_word;
          s1_data_d  = bus.data_i;
          if (last_word) state_d = ST_FILL;
        end
        ST_PASS: begin
          s1_valid_d = 1'b1;
          s1_last_d  = last_word;
          s1_data_d  = bus.data_i;
        end
        default: ;
      endcase
    end
  end

  // Data outputs hold whenever nothing is emitted
  always_comb begin
    data_1_d   = data_1_q;
    data_2_d   = data_2_q;
    max_en_d   = 1'b0;
    valid_d    = 1'b0;
    row_done_d = 1'b0;
    if (s1_valid_q) begin
      valid_d    = 1'b1;
      max_en_d   = s1_pair_q;
      row_done_d = s1_last_q;
      data_1_d   = s1_pair_q ? rd_data : s1_data_q;
      data_2_d   = s1_pair_q ? s1_data_q : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      col_q      <= '0;
      last_col_q <= '1;
      pool_en_q  <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_pair_q  <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_data_q  <= '0;
      data_1_q   <= '0;
      data_2_q   <= '0;
      max_en_q   <= 1'b0;
      valid_q    <= 1'b0;
      row_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      last_col_q <= last_col_d;
      pool_en_q  <= pool_en_d;
      s1_valid_q <= s1_valid_d;
      s1_pair_q  <= s1_pair_d;
      s1_last_q  <= s1_last_d;
      s1_data_q  <= s1_data_d;
      data_1_q   <= data_1_d;
      data_2_q   <= data_2_d;
      max_en_q   <= max_en_d;
      valid_q    <= valid_d;
      row_done_q <= row_done_d;
    end
  end

  // FILL only writes and PAIR only reads, so one shared address suffices
  max_pool_row_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (MAX_ROW_LEN),
    .ADDR_W (ADDR_W)
  ) u_row_buf (
    .clk_i     (clk_i),
    .wr_en_i   (wr_en),
    .wr_addr_i (buf_addr),
    .wr_data_i (bus.data_i),
    .rd_addr_i (buf_addr),
    .rd_data_o (rd_data)
  );

  assign bus.data_1_o   = data_1_q;
  assign bus.data_2_o   = data_2_q;
  assign bus.max_en_o   = max_en_q;
  assign bus.valid_o    = valid_q;
  assign bus.row_done_o = row_done_q;

endmodule

// File: tb/tb_max_pool_row_pair_gen.sv
// Self-checking bench for max_pool_row_pair_gen. A frame-level reference
// model (rows, columns, stored upper row) predicts each emitted pair and
// the cycle it must appear on; each scenario task compares what was
// observed on the output bus against those predictions.
module tb_max_pool_row_pair_gen;

  typedef struct packed {
    logic [47:0] d1;
    logic [47:0] d2;
    logic        men;
    logic        rd;
    int unsigned cyc;
  } pair_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  max_pool_row_pair_gen_if bus ();

  max_pool_row_pair_gen #(
    .DATA_W      (48),
    .MAX_ROW_LEN (256),
    .ADDR_W      (8)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int unsigned cyc    = 0;
  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  int unsigned stray  = 0;
  pair_t       exp_q[$];
  pair_t       obs_q[$];

  // Reference model state: frame config, position, stored even row
  bit          m_active = 1'b0;
  bit          m_pool   = 1'b0;
  int          m_len    = 256;
  int          m_col    = 0;
  int          m_row    = 0;
  logic [47:0] m_upper [256];

  function automatic logic [47:0] rnd48();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[47:0];
  endfunction

  // One clock: sample outputs at the falling edge, then drive the inputs
  // captured by the next rising edge and advance the model accordingly.
  task automatic tick(input logic fs, input logic [7:0] len, input logic pen,
                      input logic dv, input logic [47:0] d);
    pair_t p;
    bit    last;
    @(negedge clk);
    cyc++;
    if (bus.valid_o === 1'b1) begin
      p.d1 = bus.data_1_o; p.d2 = bus.data_2_o;
      p.men = bus.max_en_o; p.rd = bus.row_done_o; p.cyc = cyc;
      obs_q.push_back(p);
    end else if (bus.max_en_o !== 1'b0 || bus.row_done_o !== 1'b0) begin
      stray++;
    end
    bus.frame_start_i = fs;
    bus.row_len_i     = len;
    bus.pool_en_i     = pen;
    bus.data_valid_i  = dv;
    bus.data_i        = d;
    if (rst_n) begin
      if (fs) begin
        m_active = 1'b1; m_pool = pen;
        m_len = (len == 8'd0) ? 256 : int'(len);
        m_col = 0; m_row = 0;
      end
      if (dv && m_active) begin
        last = (m_col == m_len - 1);
        p.cyc = cyc + 2; p.rd = last;
        if (!m_pool) begin
          p.d1 = d; p.d2 = '0; p.men = 1'b0;
          exp_q.push_back(p);
        end else if (m_row % 2 == 0) begin
          m_upper[m_col] = d;
        end else begin
          p.d1 = m_upper[m_col]; p.d2 = d; p.men = 1'b1;
          exp_q.push_back(p);
        end
        m_col++;
        if (m_col == m_len) begin m_col = 0; m_row++; end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'd0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    n_chk++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", bus.valid_o); end
    n_chk++; if (bus.max_en_o !== 1'b0) begin n_fail++; $display("FAIL rst_max_en got %b want 0", bus.max_en_o); end
    n_chk++; if (bus.row_done_o !== 1'b0) begin n_fail++; $display("FAIL rst_row_done got %b want 0", bus.row_done_o); end
    n_chk++; if (bus.data_1_o !== 48'h0) begin n_fail++; $display("FAIL rst_data_1 got %h want 0", bus.data_1_o); end
    n_chk++; if (bus.data_2_o !== 48'h0) begin n_fail++; $display("FAIL rst_data_2 got %h want 0", bus.data_2_o); end
    rst_n = 1'b1;
    // Data before any frame_start is ignored
    for (int i = 0; i < 4; i++) tick(1'b0, 8'd0, 1'b0, 1'b1, rnd48());
    idle(4);
    n_chk++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL idle_ignore got %0d outputs want 0", obs_q.size()); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_pool_pairs();
    tick(1'b1, 8'd4, 1'b1, 1'b0, '0);
    for (int i = 0; i < 8; i++) tick(1'b0, 8'd0, 1'b0, 1'b1, rnd48());
    idle(4);
    n_chk++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL pool4_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL pool4_pair[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_pass_through();
    tick(1'b1, 8'd2, 1'b0, 1'b0, '0);
    tick(1'b0, 8'd0, 1'b0, 1'b1, 48'h123456789ABC);
    idle(1);
    tick(1'b0, 8'd0, 1'b0, 1'b1, 48'h000000000FFF);
    idle(4);
    n_chk++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL pass_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL pass_word[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_chk++;
    if (bus.data_1_o !== 48'h000000000FFF) begin n_fail++; $display("FAIL pass_hold got %h want %h", bus.data_1_o, 48'h000000000FFF); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_full_row_gaps();
    int rd_cnt;
    tick(1'b1, 8'd0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 512; i++) begin
      while ($urandom_range(3) == 0) idle(1);
      tick(1'b0, 8'd0, 1'b0, 1'b1, rnd48());
    end
    idle(4);
    rd_cnt = 0;
    foreach (obs_q[i]) if (obs_q[i].rd) rd_cnt++;
    n_chk++;
    if (rd_cnt !== 1) begin n_fail++; $display("FAIL full_row_done got %0d pulses want 1", rd_cnt); end
    n_chk++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL full_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL full_pair[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_frame_restart();
    tick(1'b1, 8'd4, 1'b1, 1'b0, '0);
    tick(1'b0, 8'd0, 1'b0, 1'b1, rnd48());
    tick(1'b0, 8'd0, 1'b0, 1'b1, rnd48());
    // Restart coincident with the col-2 word: it becomes column 0
    tick(1'b1, 8'd4, 1'b1, 1'b1, rnd48());
    for (int i = 0; i < 7; i++) tick(1'b0, 8'd0, 1'b0, 1'b1, rnd48());
    idle(4);
    n_chk++;
    if (obs_q.size() !== 4) begin n_fail++; $display("FAIL restart_count got %0d want 4", obs_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL restart_pair[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_async_reset();
    tick(1'b1, 8'd4, 1'b1, 1'b0, '0);
    for (int i = 0; i < 7; i++) tick(1'b0, 8'd0, 1'b0, 1'b1, rnd48());
    n_chk++;
    if (obs_q.size() !== 1) begin n_fail++; $display("FAIL arst_pre_count got %0d want 1", obs_q.size()); end
    foreach (obs_q[i]) if (i < exp_q.size()) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL arst_pre_pair[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    #2;
    n_chk++; if (bus.valid_o !== 1'b1) begin n_fail++; $display("FAIL arst_busy got %b want 1", bus.valid_o); end
    rst_n = 1'b0;
    m_active = 1'b0;
    #1;
    n_chk++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL arst_valid got %b want 0", bus.valid_o); end
    n_chk++; if (bus.max_en_o !== 1'b0) begin n_fail++; $display("FAIL arst_max_en got %b want 0", bus.max_en_o); end
    n_chk++; if (bus.data_1_o !== 48'h0 || bus.data_2_o !== 48'h0) begin
      n_fail++; $display("FAIL arst_data got %h/%h want 0/0", bus.data_1_o, bus.data_2_o); end
    idle(3);
    rst_n = 1'b1;
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 6; i++) tick(1'b0, 8'd0, 1'b0, 1'b1, rnd48());
    idle(3);
    n_chk++;
    if (obs_q.size() !== 0) begin n_fail++; $display("FAIL arst_post_idle got %0d outputs want 0", obs_q.size()); end
    tick(1'b1, 8'd4, 1'b1, 1'b0, '0);
    for (int i = 0; i < 8; i++) tick(1'b0, 8'd0, 1'b0, 1'b1, rnd48());
    idle(4);
    n_chk++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL arst_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL arst_pair[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_odd_rows();
    tick(1'b1, 8'd3, 1'b1, 1'b0, '0);
    for (int i = 0; i < 9; i++) tick(1'b0, 8'd0, 1'b0, 1'b1, rnd48());
    tick(1'b1, 8'd3, 1'b1, 1'b0, '0);
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(1) == 0) idle(1);
      tick(1'b0, 8'd0, 1'b0, 1'b1, rnd48());
    end
    idle(4);
    n_chk++;
    if (obs_q.size() !== 6) begin n_fail++; $display("FAIL odd_count got %0d want 6", obs_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL odd_pair[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_chk++;
    if (stray !== 0) begin n_fail++; $display("FAIL stray_flags got %0d cycles want 0", stray); end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    bus.frame_start_i = 1'b0;
    bus.row_len_i     = '0;
    bus.pool_en_i     = 1'b0;
    bus.data_valid_i  = 1'b0;
    bus.data_i        = '0;
    test_reset();
    test_pool_pairs();
    test_pass_through();
    test_full_row_gaps();
    test_frame_restart();
    test_async_reset();
    test_odd_rows();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
